// File: rtl/slice_reg_bank_if.sv
// ---------------------------------------------------------------------------
// slice_reg_bank_if
// Bundles the control/data signals of one slice register bank.
//   CE, SR, SHIFT_EN : control set from the CE/SR mux stage (master -> slave)
//   D, SIN           : parallel and serial data in        (master -> slave)
//   Q, SOUT          : registered storage and serial out   (slave -> master)
//   READY            : bank is in RUN and accepts inputs   (slave -> master)
// ---------------------------------------------------------------------------
interface slice_reg_bank_if #(
    parameter int WIDTH = 8
);
    logic             CE;
    logic             SR;
    logic             SHIFT_EN;
    logic [WIDTH-1:0] D;
    logic             SIN;
    logic [WIDTH-1:0] Q;
    logic             SOUT;
    logic             READY;

    modport master (
        output CE, SR, SHIFT_EN, D, SIN,
        input  Q, SOUT, READY
    );

    modport slave (
        input  CE, SR, SHIFT_EN, D, SIN,
        output Q, SOUT, READY
    );
endinterface

// File: rtl/slice_reg_bank.sv
// ---------------------------------------------------------------------------
// slice_reg_bank
// A bank of WIDTH storage bits sharing one CE/SR control set, with parallel
// load and non-circular shift modes. After reset the bank freezes Q at INIT
// for HOLD_CYCLES cycles (HOLD state) before accepting inputs (RUN state).
// Ports:
//   CLK  : single clock, rising edge
//   RST  : synchronous active-high reset (forces Q=INIT, HOLD, READY=0)
//   bus  : slave side of slice_reg_bank_if (CE, SR, SHIFT_EN, D, SIN in;
//          Q, SOUT, READY out)
// ---------------------------------------------------------------------------
module slice_reg_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter logic [WIDTH-1:0] SRVAL       = '0,
    parameter bit               SRCE        = 1'b0,
    parameter int               HOLD_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    slice_reg_bank_if.slave  bus
);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Count value on which the last hold edge occurs. HOLD_CYCLES of 0 and 1
    // both leave HOLD on the first edge after reset is released.
    localparam logic [7:0] HOLD_LAST = 8'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shift_vec;
    logic             sr_eff;

    // Shifted image of Q: SIN enters at bit 0, the old MSB drops off.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shift_vec[gi] = bus.SIN;
            end else begin : g_upper
                assign shift_vec[gi] = q_q[gi-1];
            end
        end
    endgenerate

    // With SRCE set, SR is qualified by CE like an ordinary data update.
    assign sr_eff = bus.SR && (!SRCE || bus.CE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            ST_HOLD: begin
                q_d = INIT;
                if ((HOLD_CYCLES == 0) || (cnt_q == HOLD_LAST)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (sr_eff) begin
                    q_d = SRVAL;
                end else if (bus.CE && bus.SHIFT_EN) begin
                    q_d = shift_vec;
                end else if (bus.CE) begin
                    q_d = bus.D;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                q_d     = INIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            q_q     <= INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    // READY comes straight from the state flop, so it is registered.
    assign bus.READY = (state_q == ST_RUN);
    assign bus.Q     = q_q;
    assign bus.SOUT  = q_q[WIDTH-1];

endmodule

// File: tb/tb_slice_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_slice_reg_bank
// Three bank configurations share one stimulus bus:
//   dut 0 : INIT=A5, SRVAL=3C, SRCE=0, HOLD_CYCLES=4
//   dut 1 : INIT=A5, SRVAL=3C, SRCE=1, HOLD_CYCLES=4
//   dut 2 : INIT=A5, SRVAL=3C, SRCE=0, HOLD_CYCLES=0
// Each directed step pushes the hand-computed result for the dut under test;
// a monitor pops one entry per clock and compares Q, READY and SOUT.
// ---------------------------------------------------------------------------
module tb_slice_reg_bank;

    logic       clk = 1'b0;
    logic       rst_s = 1'b1;
    logic       ce_s = 1'b0;
    logic       sr_s = 1'b0;
    logic       sh_s = 1'b0;
    logic [7:0] d_s = 8'h00;
    logic       sin_s = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         dut;
        logic [7:0] q;
        logic       rdy;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    slice_reg_bank_if #(.WIDTH(8)) if0 ();
    slice_reg_bank_if #(.WIDTH(8)) if1 ();
    slice_reg_bank_if #(.WIDTH(8)) if2 ();

    assign if0.CE = ce_s;  assign if0.SR = sr_s;  assign if0.SHIFT_EN = sh_s;
    assign if0.D  = d_s;   assign if0.SIN = sin_s;
    assign if1.CE = ce_s;  assign if1.SR = sr_s;  assign if1.SHIFT_EN = sh_s;
    assign if1.D  = d_s;   assign if1.SIN = sin_s;
    assign if2.CE = ce_s;  assign if2.SR = sr_s;  assign if2.SHIFT_EN = sh_s;
    assign if2.D  = d_s;   assign if2.SIN = sin_s;

    slice_reg_bank #(.WIDTH(8), .INIT(8'hA5), .SRVAL(8'h3C), .SRCE(1'b0), .HOLD_CYCLES(4))
        dut0 (.CLK(clk), .RST(rst_s), .bus(if0));
    slice_reg_bank #(.WIDTH(8), .INIT(8'hA5), .SRVAL(8'h3C), .SRCE(1'b1), .HOLD_CYCLES(4))
        dut1 (.CLK(clk), .RST(rst_s), .bus(if1));
    slice_reg_bank #(.WIDTH(8), .INIT(8'hA5), .SRVAL(8'h3C), .SRCE(1'b0), .HOLD_CYCLES(0))
        dut2 (.CLK(clk), .RST(rst_s), .bus(if2));

    // One clock per step: drive inputs at negedge, record what the selected
    // dut must show after the following rising edge.
    task automatic step(input int dut, input logic rst, input logic ce,
                        input logic sr, input logic sh, input logic [7:0] d,
                        input logic sin, input logic [7:0] eq, input logic er,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst_s = rst; ce_s = ce; sr_s = sr; sh_s = sh; d_s = d; sin_s = sin;
        e.dut = dut; e.q = eq; e.rdy = er; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic       ar, as;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.dut)
                    0:       begin aq = if0.Q; ar = if0.READY; as = if0.SOUT; end
                    1:       begin aq = if1.Q; ar = if1.READY; as = if1.SOUT; end
                    default: begin aq = if2.Q; ar = if2.READY; as = if2.SOUT; end
                endcase
                n_checks++;
                if (aq !== e.q) begin
                    n_fail++;
                    $display("FAIL %s dut%0d Q: got %h expected %h", e.nm, e.dut, aq, e.q);
                end
                n_checks++;
                if (ar !== e.rdy) begin
                    n_fail++;
                    $display("FAIL %s dut%0d READY: got %b expected %b", e.nm, e.dut, ar, e.rdy);
                end
                n_checks++;
                if (as !== e.q[7]) begin
                    n_fail++;
                    $display("FAIL %s dut%0d SOUT: got %b expected %b", e.nm, e.dut, as, e.q[7]);
                end
                $display("check %s dut%0d Q=%h READY=%b SOUT=%b", e.nm, e.dut, aq, ar, as);
            end
        end
    end

    initial begin
        // ---- dut 0: startup with CE=1, D=FF held during reset and hold
        step(0, 1, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "rst");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "hold1");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "hold2");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "hold3");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 1, "hold4_ready");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hFF, 1, "first_load");
        step(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1, "load00");
        // ---- shift 1,0,1,1 then zeros: MSB falls off, no wrap
        step(0, 0, 1, 0, 1, 8'hFF, 1, 8'h01, 1, "sh1");
        step(0, 0, 1, 0, 1, 8'hFF, 0, 8'h02, 1, "sh2");
        step(0, 0, 1, 0, 1, 8'hFF, 1, 8'h05, 1, "sh3");
        step(0, 0, 1, 0, 1, 8'hFF, 1, 8'h0B, 1, "sh4");
        step(0, 0, 1, 0, 1, 8'hFF, 0, 8'h16, 1, "sh5");
        step(0, 0, 1, 0, 1, 8'hFF, 0, 8'h2C, 1, "sh6");
        step(0, 0, 1, 0, 1, 8'hFF, 0, 8'h58, 1, "sh7");
        step(0, 0, 1, 0, 1, 8'hFF, 0, 8'hB0, 1, "sh8");
        step(0, 0, 1, 0, 1, 8'hFF, 0, 8'h60, 1, "sh9_noncirc");
        step(0, 0, 0, 0, 1, 8'hFF, 1, 8'h60, 1, "ce0_hold");
        // ---- SR without CE (SRCE=0)
        step(0, 0, 0, 1, 0, 8'hFF, 0, 8'h3C, 1, "sr_ce0");
        step(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1, "load00b");
        step(0, 0, 1, 1, 1, 8'hFF, 1, 8'h3C, 1, "sr_over_shift");
        // ---- reset beats SR
        step(0, 1, 1, 1, 0, 8'hFF, 0, 8'hA5, 0, "rst_with_sr");
        // ---- reset again two cycles into hold
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "mh1");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "mh2");
        step(0, 1, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "mh_rst");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "mh_h1");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "mh_h2");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "mh_h3");
        step(0, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 1, "mh_h4_ready");
        step(0, 0, 0, 0, 0, 8'h00, 0, 8'hA5, 1, "run_stays1");
        step(0, 0, 0, 0, 0, 8'h00, 0, 8'hA5, 1, "run_stays2");

        // ---- dut 1: SR qualified by CE
        step(1, 1, 0, 0, 0, 8'h00, 0, 8'hA5, 0, "srce_rst");
        step(1, 0, 0, 0, 0, 8'h00, 0, 8'hA5, 0, "srce_h1");
        step(1, 0, 0, 0, 0, 8'h00, 0, 8'hA5, 0, "srce_h2");
        step(1, 0, 0, 0, 0, 8'h00, 0, 8'hA5, 0, "srce_h3");
        step(1, 0, 0, 0, 0, 8'h00, 0, 8'hA5, 1, "srce_h4");
        step(1, 0, 1, 0, 0, 8'h5A, 0, 8'h5A, 1, "srce_load");
        step(1, 0, 0, 1, 0, 8'hFF, 0, 8'h5A, 1, "srce_sr_ce0");
        step(1, 0, 1, 1, 0, 8'hFF, 0, 8'h3C, 1, "srce_sr_ce1");
        step(1, 0, 1, 0, 0, 8'h81, 0, 8'h81, 1, "srce_load81");
        step(1, 0, 1, 1, 1, 8'hFF, 1, 8'h3C, 1, "srce_sr_shift");

        // ---- dut 2: zero hold
        step(2, 1, 1, 0, 0, 8'hFF, 0, 8'hA5, 0, "z_rst");
        step(2, 0, 1, 0, 0, 8'hFF, 0, 8'hA5, 1, "z_ready_ignored");
        step(2, 0, 1, 0, 0, 8'h12, 0, 8'h12, 1, "z_load");

        @(negedge clk);
        rst_s = 1'b0; ce_s = 1'b0; sr_s = 1'b0; sh_s = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slice_reg_bank.md
SLICE_REG_BANK -- requirements
Module: slice_reg_bank

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 8, number of storage bits sharing one CE/SR control set; legal range 2..32.
  INIT, 0 (WIDTH bits), value loaded into Q on RST and held through the startup hold.
  SRVAL, 0 (WIDTH bits), value loaded into Q when SR is effective.
  SRCE, 0, 0 = SR acts regardless of CE; 1 = SR acts only when CE=1.
  HOLD_CYCLES, 4, cycles Q is frozen at INIT after RST deasserts; legal range 0..255.
REQ-002 Ports SHALL be, one per line:
  CLK       input   1      single clock; all state updates on rising edge.
  RST       input   1      synchronous, active-high reset.
  CE        input   1      clock enable from the CE/SR mux stage (CE_OUT).
  SR        input   1      synchronous set/reset from the CE/SR mux stage (SR_OUT).
  SHIFT_EN  input   1      1 = shift mode, 0 = parallel load mode.
  D         input   WIDTH  parallel data in.
  SIN       input   1      serial data in, enters at Q[0].
  Q         output  WIDTH  registered storage outputs.
  SOUT      output  1      serial out, equals Q[WIDTH-1].
  READY     output  1      1 = bank is in RUN state and accepts CE/SR/D.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; no asynchronous or gated-clock logic.

Function
REQ-004 The block SHALL implement a two-state FSM: HOLD and RUN.
REQ-005 In HOLD, Q SHALL keep INIT; CE, SR, SHIFT_EN, D and SIN SHALL be ignored; READY SHALL be 0.
REQ-006 In HOLD, an 8-bit hold counter SHALL increment by one each cycle; when it equals HOLD_CYCLES-1, the FSM SHALL move to RUN on that edge.
REQ-007 If HOLD_CYCLES=0, the FSM SHALL enter RUN on the first edge with RST=0, so READY=1 one cycle after RST deasserts.
REQ-008 READY SHALL be registered and SHALL equal 1 exactly when the FSM is in RUN.
REQ-009 In RUN, the following priority SHALL apply per edge, highest first:
  (a) SR effective (SR=1 and, if SRCE=1, CE=1): Q <= SRVAL.
  (b) CE=1 and SHIFT_EN=1: Q <= {Q[WIDTH-2:0], SIN}.
  (c) CE=1 and SHIFT_EN=0: Q <= D.
  (d) otherwise: Q holds.
REQ-010 With SRCE=1, SR=1 and CE=0, Q SHALL hold; SR SHALL NOT take effect.
REQ-011 SR=1 together with CE=1 and SHIFT_EN=1 SHALL load SRVAL; no shift SHALL occur on that edge.
REQ-012 SOUT SHALL be the combinational copy of Q[WIDTH-1], so it has the same latency as Q, with no extra register.
REQ-013 The shift SHALL be non-circular: the old Q[WIDTH-1] leaves through SOUT and is lost on the next shift.
REQ-014 All updates SHALL have one-cycle latency: inputs sampled at edge N appear on Q after edge N.
REQ-015 The FSM SHALL NOT return from RUN to HOLD except through RST.

Reset
REQ-016 RST=1 at an edge SHALL force Q=INIT, hold counter=0, FSM=HOLD and READY=0, overriding all other inputs including SR.
REQ-017 RST asserted mid-HOLD SHALL restart the hold count from 0.
REQ-018 RST asserted in RUN SHALL abort any shift or load in progress; the full HOLD_CYCLES hold SHALL repeat after RST deasserts.
REQ-019 Q SHALL have no undefined value after the first RST edge; there SHALL be no power-up behaviour other than via RST.

Verification
REQ-020 Startup: WIDTH=8, INIT=8'hA5, HOLD_CYCLES=4; pulse RST, drive CE=1, D=8'hFF -> Q=8'hA5 and READY=0 for 4 cycles after RST deasserts; READY=1 after the 4th edge; Q=8'hFF one edge later.
REQ-021 Shift: in RUN with Q=8'h00, SHIFT_EN=1, CE=1 and SIN sequence 1,0,1,1 -> Q=8'h0B after 4 edges; SOUT=0 throughout.
REQ-022 SR priority: SRVAL=8'h3C, SRCE=0; in RUN drive SR=1, CE=0 -> Q=8'h3C next edge. With SRCE=1, the same stimulus -> Q unchanged; adding CE=1 -> Q=8'h3C.
REQ-023 Simultaneous events: in RUN drive SR=1, CE=1, SHIFT_EN=1, SIN=1 -> Q=SRVAL (no shift); then RST=1 together with SR=1 -> Q=INIT and READY=0.
REQ-024 Zero hold: HOLD_CYCLES=0 -> READY=1 one edge after RST deasserts; a D load on that edge is ignored, and a D load on the following edge appears on Q.
REQ-025 Mid-hold reset: HOLD_CYCLES=4; assert RST again 2 cycles into HOLD -> READY stays 0 until 4 full cycles after the second RST deasserts.
